// File: rtl/alu_sched_pkg.sv
// Shared types and result-word field layout for the subtract-unit scheduler.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int SUB_RES_W = 13;
    localparam int MAG_LSB   = 0;
    localparam int MAG_MSB   = 7;
    localparam int NEG_BIT   = 9;

    // Bits 12:10 and 8 must read back as zero from a healthy subtract unit.
    localparam logic [SUB_RES_W-1:0] RSVD_MASK = 13'h1D00;

endpackage

// File: rtl/arb2_rr.sv
// Two-way request arbiter; round-robin when ALU_SUB_SCHED_RR_EN is defined,
// otherwise fixed priority with requester 0 always winning.
module arb2_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

`ifdef ALU_SUB_SCHED_RR_EN
    // prio_q=1 means requester 1 wins the next contention
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
    end

    // Pointer only moves on an actual accept, never on a bare grant.
    always_comb begin
        prio_d = prio_q;
        if (accept) begin
            prio_d = gnt[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, accept};

    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_sub_sched.sv
// Shares one registered magnitude-subtract unit between two requesters.
// Arbitration mode selected by ALU_SUB_SCHED_RR_EN (see arb2_rr).
//
// state | meaning
// IDLE  | no operation in flight, grant offered to a pending requester
// WAIT  | operands on sub_x/sub_y, counting down the unit latency
// RESP  | result held for the owner until it asserts rsp_ready
module alu_sub_sched
    import alu_sched_pkg::*;
#(
    parameter int SUB_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    input  logic [7:0]           req_a0,
    input  logic [7:0]           req_b0,
    input  logic [7:0]           req_a1,
    input  logic [7:0]           req_b1,
    output logic [1:0]           req_ready,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [7:0]           rsp_mag,
    output logic                 rsp_neg,
    output logic [7:0]           sub_x,
    output logic [7:0]           sub_y,
    input  logic [SUB_RES_W-1:0] sub_res,
    output logic                 fmt_err,
    output logic [CNT_W-1:0]     ops_done,
    output logic                 busy
);

    localparam logic [2:0] CNT_INIT = 3'(SUB_LAT - 1);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic [7:0]       sub_x_q, sub_x_d;
    logic [7:0]       sub_y_q, sub_y_d;
    logic [7:0]       rsp_mag_q, rsp_mag_d;
    logic             rsp_neg_q, rsp_neg_d;
    logic             fmt_err_q, fmt_err_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic [1:0] gnt;
    logic       accept;

    arb2_rr u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept),
        .gnt    (gnt)
    );

    assign req_ready = (state_q == IDLE) ? gnt : 2'b00;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        sub_x_d    = sub_x_q;
        sub_y_d    = sub_y_q;
        rsp_mag_d  = rsp_mag_q;
        rsp_neg_d  = rsp_neg_q;
        fmt_err_d  = fmt_err_q;
        ops_done_d = ops_done_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = gnt[1];
                    sub_x_d = gnt[1] ? req_a1 : req_a0;
                    sub_y_d = gnt[1] ? req_b1 : req_b0;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    rsp_mag_d = sub_res[MAG_MSB:MAG_LSB];
                    rsp_neg_d = sub_res[NEG_BIT];
                    fmt_err_d = fmt_err_q | (|(sub_res & RSVD_MASK));
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    ops_done_d = ops_done_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            owner_q    <= 1'b0;
            sub_x_q    <= 8'd0;
            sub_y_q    <= 8'd0;
            rsp_mag_q  <= 8'd0;
            rsp_neg_q  <= 1'b0;
            fmt_err_q  <= 1'b0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            sub_x_q    <= sub_x_d;
            sub_y_q    <= sub_y_d;
            rsp_mag_q  <= rsp_mag_d;
            rsp_neg_q  <= rsp_neg_d;
            fmt_err_q  <= fmt_err_d;
            ops_done_q <= ops_done_d;
        end
    end

    assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_mag   = rsp_mag_q;
    assign rsp_neg   = rsp_neg_q;
    assign sub_x     = sub_x_q;
    assign sub_y     = sub_y_q;
    assign fmt_err   = fmt_err_q;
    assign ops_done  = ops_done_q;
    assign busy      = (state_q != IDLE);

endmodule
